// File: rtl/shreg_pkg.sv
// Shared types for the shift-register command sequencer.
// Opcodes, FSM states and the buffered command bundle.
package shreg_pkg;

  localparam int SR_W     = 8;
  localparam int SR_CNT_W = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_HOLD = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    op_e                 op;
    logic [SR_CNT_W-1:0] cnt;
    logic [SR_W-1:0]     data;
  } cmd_t;

  // Index of the final step: repeatable ops run max(cnt,1) steps.
  function automatic logic [SR_CNT_W-1:0] last_step(
    input op_e                 op,
    input logic [SR_CNT_W-1:0] cnt
  );
    logic [SR_CNT_W-1:0] r;
    r = '0;
    unique case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_HOLD:
        r = (cnt == '0) ? '0 : cnt - SR_CNT_W'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shreg_cmd_fifo.sv
// Small synchronous FIFO holding queued sequencer commands.
// Read data is the head entry, valid whenever not empty.
module shreg_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/shreg_cmd_seq.sv
// Command sequencer driving the universal shift register controls.
// Strobes are decoded from next-state so they line up with EXEC steps.
module shreg_cmd_seq
  import shreg_pkg::*;
#(
  parameter int WIDTH      = SR_W,
  parameter int CNT_W      = SR_CNT_W,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int IW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             pl,
  output logic             sl,
  output logic             sr,
  output logic             rl,
  output logic             rr,
  output logic             si,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW:0]      fifo_count
);

  cmd_t            in_cmd;
  cmd_t            head;
  cmd_t            cur_q, cur_d;
  state_e          state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [IW-1:0]   sidx;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic            last;
  logic            pl_q, pl_d;
  logic            sl_q, sl_d;
  logic            sr_q, sr_d;
  logic            rl_q, rl_d;
  logic            rr_q, rr_d;
  logic            si_q, si_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  assign in_cmd = '{op: op_e'(cmd_op), cnt: cmd_cnt, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign push = cmd_valid && cmd_ready;

  shreg_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_cmd),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last = step_q == last_step(cur_q.op, cur_q.cnt);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = step_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          step_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!last) begin
          step_d = step_q + CNT_W'(1);
        end else if (!fifo_empty) begin
          pop    = 1'b1;
          cur_d  = head;
          step_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pl_d   = 1'b0;
    sl_d   = 1'b0;
    sr_d   = 1'b0;
    rl_d   = 1'b0;
    rr_d   = 1'b0;
    si_d   = 1'b0;
    done_d = 1'b0;
    sidx   = IW'(step_d % CNT_W'(WIDTH));
    err_d  = err_q || (pop && head.op == OP_RSVD);
    if (state_d == ST_EXEC) begin
      done_d = step_d == last_step(cur_d.op, cur_d.cnt);
      unique case (cur_d.op)
        OP_LOAD: pl_d = 1'b1;
        OP_SHL: begin
          sl_d = cur_d.cnt != '0;
          si_d = sl_d && cur_d.data[sidx];
        end
        OP_SHR: begin
          sr_d = cur_d.cnt != '0;
          si_d = sr_d && cur_d.data[sidx];
        end
        OP_ROL:  rl_d = cur_d.cnt != '0;
        OP_ROR:  rr_d = cur_d.cnt != '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      step_q  <= '0;
      pl_q    <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      rl_q    <= 1'b0;
      rr_q    <= 1'b0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      pl_q    <= pl_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      rl_q    <= rl_d;
      rr_q    <= rr_d;
      si_q    <= si_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pl   = pl_q;
  assign sl   = sl_q;
  assign sr   = sr_q;
  assign rl   = rl_q;
  assign rr   = rr_q;
  assign si   = si_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q == ST_EXEC) || (fifo_count != '0);

endmodule

// File: tb/tb_shreg_cmd_seq.sv
// Directed and random bench for the shift-register command sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shreg_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] cmd_data;
  logic       pl, sl, sr, rl, rr, si;
  logic       busy, done, err;
  logic [2:0] fifo_count;
  logic [4:0] strb;

  int checks = 0;
  int errors = 0;

  assign strb = {pl, sl, sr, rl, rr};

  always #5 clk = ~clk;

  shreg_cmd_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_cnt    (cmd_cnt),
    .cmd_data   (cmd_data),
    .pl         (pl),
    .sl         (sl),
    .sr         (sr),
    .rl         (rl),
    .rr         (rr),
    .si         (si),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] cnt,
                      input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    chk("push_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int  waited;
    int  cyc, sent, bad, ones;
    int  n_pl, n_sl, n_sr, n_rl, n_rr, n_done;
    int  e_pl, e_sl, e_sr, e_rl, e_rr, e_done;
    logic [2:0] rop;
    logic [3:0] rcnt;
    logic [7:0] shl_d;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_cnt   = '0;
    cmd_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_strb", strb, 0);
    chk("rst_flags", {si, busy, done, err}, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD: pl only in the second cycle after the push edge
    push(3'd1, 4'd0, 8'h00);
    chk("ld_c1_strb", strb, 0);
    chk("ld_c1_cnt", fifo_count, 1);
    chk("ld_c1_busy", busy, 1);
    @(negedge clk);
    chk("ld_c2_strb", strb, 5'b10000);
    chk("ld_c2_done", done, 1);
    chk("ld_c2_busy", busy, 1);
    @(negedge clk);
    chk("ld_c3_strb", strb, 0);
    chk("ld_c3_done_busy", {done, busy}, 0);

    // SHL cnt=4 data=0000_1011 -> si 1,1,0,1
    push(3'd2, 4'd4, 8'b0000_1011);
    chk("shl_lat", strb, 0);
    shl_d = 8'b0000_1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("shl_sl", strb, 5'b01000);
      chk("shl_si", si, shl_d[k]);
      chk("shl_done", done, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("shl_end", {strb, busy}, 0);

    // SHL cnt=10 data=01: step index wraps at 8
    push(3'd2, 4'd10, 8'h01);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("wrap_sl", sl, 1);
      chk("wrap_si", si, (k % 8 == 0) ? 1 : 0);
    end
    @(negedge clk);
    chk("wrap_end", {strb, busy}, 0);

    // Long HOLD lets 4 RORs fill the FIFO, then 5 run back to back
    push(3'd6, 4'd15, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_cnt   = 4'd2;
    cmd_data  = 8'h00;
    repeat (4) @(negedge clk);
    chk("fill_cnt", fifo_count, 4);
    chk("fill_ready", cmd_ready, 0);
    chk("hold_strb", strb, 0);
    waited = 0;
    while (!cmd_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("fill_wait", cmd_ready, 1);
    for (int j = 0; j < 10; j++) begin
      chk("ror_rr", strb, 5'b00001);
      chk("ror_done", done, (j % 2 == 1) ? 1 : 0);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("ror_end", strb, 0);
    chk("ror_idle", busy, 0);

    // ROL cnt=0, HOLD cnt=3, reserved op
    push(3'd4, 4'd0, 8'h00);
    push(3'd6, 4'd3, 8'h00);
    chk("rol0_strb", strb, 0);
    chk("rol0_done", done, 1);
    chk("rol0_err", err, 0);
    push(3'd7, 4'd5, 8'hFF);
    chk("hold_s0", {strb, done}, 0);
    @(negedge clk);
    chk("hold_s1", {strb, done}, 0);
    @(negedge clk);
    chk("hold_s2", {strb, done}, 1);
    @(negedge clk);
    chk("rsvd_strb", strb, 0);
    chk("rsvd_done_err", {done, err}, 2'b11);
    @(negedge clk);
    chk("rsvd_after", {busy, done, err}, 3'b001);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);

    // Reset mid SHR cnt=10 at step 5 with 2 queued
    push(3'd3, 4'd10, 8'hA5);
    push(3'd1, 4'd0, 8'h00);
    push(3'd2, 4'd3, 8'hFF);
    chk("mid_cnt", fifo_count, 2);
    repeat (4) @(negedge clk);
    chk("mid_sr", strb, 5'b00100);
    chk("mid_si", si, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strb", {strb, si}, 0);
    chk("arst_cnt", fifo_count, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst", {strb, busy, done}, 0);
    end

    // Random stream against a strobe-count model
    sent = 0; cyc = 0; bad = 0;
    n_pl = 0; n_sl = 0; n_sr = 0; n_rl = 0; n_rr = 0; n_done = 0;
    e_pl = 0; e_sl = 0; e_sr = 0; e_rl = 0; e_rr = 0; e_done = 0;
    while ((sent < 200 || busy) && cyc < 6000) begin
      ones = int'(pl) + int'(sl) + int'(sr) + int'(rl) + int'(rr);
      if (ones > 1) bad++;
      n_pl += int'(pl);
      n_sl += int'(sl);
      n_sr += int'(sr);
      n_rl += int'(rl);
      n_rr += int'(rr);
      n_done += int'(done);
      cmd_valid = 1'b0;
      if (sent < 200 && $urandom_range(0, 3) != 0) begin
        rop       = 3'($urandom_range(0, 6));
        rcnt      = 4'($urandom_range(0, 15));
        cmd_op    = rop;
        cmd_cnt   = rcnt;
        cmd_data  = 8'($urandom);
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          sent++;
          e_done++;
          case (rop)
            3'd1: e_pl++;
            3'd2: e_sl += int'(rcnt);
            3'd3: e_sr += int'(rcnt);
            3'd4: e_rl += int'(rcnt);
            3'd5: e_rr += int'(rcnt);
            default: ;
          endcase
        end
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("rnd_finish", busy, 0);
    chk("rnd_sent", sent, 200);
    chk("rnd_onehot", bad, 0);
    chk("rnd_pl", n_pl, e_pl);
    chk("rnd_sl", n_sl, e_sl);
    chk("rnd_sr", n_sr, e_sr);
    chk("rnd_rl", n_rl, e_rl);
    chk("rnd_rr", n_rr, e_rr);
    chk("rnd_done", n_done, e_done);
    chk("rnd_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
